// File: rtl/rtc_bus_arbiter_pkg.sv
// rtc_bus_arbiter_pkg
// Shared definitions for the RTC multiplexed-bus arbiter and the read/write
// sequencers that drive it. Contents:
//   state_e   - 3-bit bus-cycle state encoding
//   *_IDLE    - inactive levels of the active-low RTC control lines
//   xfer_t    - transaction latched on grant (type, address, write data)
//   max3      - helper used to size the phase timer
package rtc_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_SET = 3'd1,
        ST_A_STB = 3'd2,
        ST_A_HLD = 3'd3,
        ST_D_SET = 3'd4,
        ST_D_STB = 3'd5,
        ST_D_HLD = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // Inactive levels of the RTC control lines (all active-low)
    localparam logic CS_IDLE  = 1'b1;
    localparam logic RD_IDLE  = 1'b1;
    localparam logic WR_IDLE  = 1'b1;
    localparam logic A_D_IDLE = 1'b1;

    typedef struct packed {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_phase_timer.sv
// rtc_phase_timer
// Down-counter that times each bus-cycle phase. It is loaded on phase entry
// and counts down to 1, where it holds; it never wraps.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   load     in  load 'value' on this edge (takes priority over counting)
//   value    in  phase length in clk cycles (>= 1)
//   expired  out high during the final cycle of the phase (count == 1)
module rtc_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q > W'(1)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Owns the RTC multiplexed AD bus and shares it between the write and read
// sequencers. Write wins when both request in IDLE. The granted transaction
// is latched, then driven as an address phase followed by a data phase, each
// with setup / strobe / hold timing, and closed by a one-cycle DONE that
// carries the matching ack.
//
// state  | meaning
// IDLE   | bus free, arbitrate requests
// A_SET  | address driven, A_D low, before WR strobe
// A_STB  | address strobe (WR low)
// A_HLD  | address held after strobe
// D_SET  | data phase setup (write: data driven; read: bus released)
// D_STB  | data strobe (WR low for write, RD low for read)
// D_HLD  | data phase hold after strobe
// DONE   | control lines idle, ack pulsed, busy still high
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data   write request (held until wr_ack), addr, data
//   wr_ack                   1-cycle pulse when the write cycle completes
//   rd_req/rd_addr           read request (held until rd_ack), addr
//   rd_data/rd_ack           last read value; 1-cycle pulse on completion
//   busy                     high from grant through DONE
//   ad_in/ad_out/ad_oe       bidirectional AD bus pad interface
//   CS/RD/WR/A_D             RTC control lines, active-low, idle high
// All outputs are registered.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       busy,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       A_D
);

    localparam int unsigned TW = $clog2(max3(T_SETUP, T_PULSE, T_HOLD) + 1);

    state_e     state_q, state_d;
    xfer_t      xfer_q, xfer_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_ack_q, rd_ack_d;
    logic       busy_q, busy_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       a_d_q, a_d_d;

    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_expired;

    function automatic logic [TW-1:0] dur(input state_e s);
        case (s)
            ST_A_SET, ST_D_SET: dur = TW'(T_SETUP);
            ST_A_STB, ST_D_STB: dur = TW'(T_PULSE);
            ST_A_HLD, ST_D_HLD: dur = TW'(T_HOLD);
            default:            dur = TW'(1);
        endcase
    endfunction

    function automatic state_e next_phase(input state_e s);
        case (s)
            ST_A_SET: next_phase = ST_A_STB;
            ST_A_STB: next_phase = ST_A_HLD;
            ST_A_HLD: next_phase = ST_D_SET;
            ST_D_SET: next_phase = ST_D_STB;
            ST_D_STB: next_phase = ST_D_HLD;
            ST_D_HLD: next_phase = ST_DONE;
            default:  next_phase = ST_IDLE;
        endcase
    endfunction

    rtc_phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // Next state, latched transaction and read capture
    always_comb begin
        state_d   = state_q;
        xfer_d    = xfer_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d          = ST_A_SET;
                    xfer_d.is_write  = 1'b1;
                    xfer_d.addr      = wr_addr;
                    xfer_d.data      = wr_data;
                end else if (rd_req) begin
                    state_d          = ST_A_SET;
                    xfer_d.is_write  = 1'b0;
                    xfer_d.addr      = rd_addr;
                    xfer_d.data      = 8'h00;
                end
            end
            // DONE always falls back to IDLE so CS gets a minimum high time
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (timer_expired) begin
                    state_d = next_phase(state_q);
                    // Last RD-low cycle: sample the pad before RD rises
                    if (state_q == ST_D_STB && !xfer_q.is_write) begin
                        rd_data_d = ad_in;
                    end
                end
            end
        endcase
        timer_load  = (state_d != state_q);
        timer_value = dur(state_d);
    end

    // Outputs are decoded from the next state so the flops line up with state_q
    always_comb begin
        cs_d     = CS_IDLE;
        rd_d     = RD_IDLE;
        wr_d     = WR_IDLE;
        a_d_d    = A_D_IDLE;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        wr_ack_d = 1'b0;
        rd_ack_d = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_d)
            ST_A_SET, ST_A_STB, ST_A_HLD: begin
                cs_d     = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = xfer_d.addr;
                wr_d     = (state_d != ST_A_STB);
            end
            ST_D_SET, ST_D_STB, ST_D_HLD: begin
                cs_d = 1'b0;
                if (xfer_d.is_write) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = xfer_d.data;
                    wr_d     = (state_d != ST_D_STB);
                end else begin
                    rd_d = (state_d != ST_D_STB);
                end
            end
            ST_DONE: begin
                wr_ack_d = xfer_d.is_write;
                rd_ack_d = !xfer_d.is_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            xfer_q    <= '0;
            rd_data_q <= 8'h00;
            ad_out_q  <= 8'h00;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            ad_oe_q   <= 1'b0;
            cs_q      <= CS_IDLE;
            rd_q      <= RD_IDLE;
            wr_q      <= WR_IDLE;
            a_d_q     <= A_D_IDLE;
        end else begin
            state_q   <= state_d;
            xfer_q    <= xfer_d;
            rd_data_q <= rd_data_d;
            ad_out_q  <= ad_out_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
            ad_oe_q   <= ad_oe_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            a_d_q     <= a_d_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ad_out  = ad_out_q;
    assign wr_ack  = wr_ack_q;
    assign rd_ack  = rd_ack_q;
    assign busy    = busy_q;
    assign ad_oe   = ad_oe_q;
    assign CS      = cs_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign A_D     = a_d_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter. Edge numbering: inputs are driven just
// after edge 0, and "edge k" values are sampled 1 time unit after edge k.
module tb_rtc_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;

    // DUT with short timing 1/3/1
    logic       wr_req, rd_req;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data, ad_in, ad_out;
    logic       wr_ack, rd_ack, busy, ad_oe, CS, RD, WR, A_D;
    logic [7:0] rd_model_val;

    // DUT with default timing 2/10/2
    logic       d_wr_req, d_rd_req;
    logic [7:0] d_wr_addr, d_wr_data, d_rd_addr;
    logic [7:0] d_rd_data, d_ad_in, d_ad_out;
    logic       d_wr_ack, d_rd_ack, d_busy, d_ad_oe, d_cs, d_rd, d_wr, d_a_d;

    int checks = 0;
    int fails  = 0;
    int viol   = 0;
    logic mon_en = 1'b0;

    logic [7:0] ctl, exp_ctl;

    always #5 clk = ~clk;

    // RTC model: drives the bus only while RD is low, garbage otherwise
    assign ad_in   = (RD   == 1'b0) ? rd_model_val : 8'hEE;
    assign d_ad_in = (d_rd == 1'b0) ? 8'hA5        : 8'hEE;

    assign ctl = {CS, RD, WR, A_D, ad_oe, busy, wr_ack, rd_ack};

    rtc_bus_arbiter #(.T_SETUP(1), .T_PULSE(3), .T_HOLD(1)) u_dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
        .busy(busy), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .CS(CS), .RD(RD), .WR(WR), .A_D(A_D)
    );

    rtc_bus_arbiter u_dut_def (
        .clk(clk), .reset(reset),
        .wr_req(d_wr_req), .wr_addr(d_wr_addr), .wr_data(d_wr_data), .wr_ack(d_wr_ack),
        .rd_req(d_rd_req), .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_ack(d_rd_ack),
        .busy(d_busy), .ad_in(d_ad_in), .ad_out(d_ad_out), .ad_oe(d_ad_oe),
        .CS(d_cs), .RD(d_rd), .WR(d_wr), .A_D(d_a_d)
    );

    // Bus-safety monitor, every cycle on both instances
    always @(negedge clk) begin
        if (mon_en) begin
            if (ad_oe === 1'b1 && RD === 1'b0)    viol++;
            if (RD === 1'b0 && WR === 1'b0)       viol++;
            if (d_ad_oe === 1'b1 && d_rd === 1'b0) viol++;
            if (d_rd === 1'b0 && d_wr === 1'b0)   viol++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (ctl !== 8'hF0) begin
            $display("FAIL reset_ctl got %b want %b", ctl, 8'hF0); fails++;
        end
        checks++;
        if (ad_out !== 8'h00 || rd_data !== 8'h00) begin
            $display("FAIL reset_bus got ad_out=%h rd_data=%h want 00/00", ad_out, rd_data); fails++;
        end
        checks++;
        if ({d_cs, d_rd, d_wr, d_a_d, d_ad_oe, d_busy, d_wr_ack, d_rd_ack} !== 8'hF0) begin
            $display("FAIL reset_ctl_def got %b want %b",
                     {d_cs, d_rd, d_wr, d_a_d, d_ad_oe, d_busy, d_wr_ack, d_rd_ack}, 8'hF0);
            fails++;
        end
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
    endtask

    // Write cycle; inputs scrambled after grant must be ignored
    task automatic test_write;
        logic [7:0] exp_out;
        tick();
        wr_addr = 8'h21; wr_data = 8'h59; wr_req = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_ctl = {!(e <= 10), 1'b1, !((e >= 2 && e <= 4) || (e >= 7 && e <= 9)),
                       !(e <= 5), (e <= 10), (e <= 11), (e == 11), 1'b0};
            exp_out = (e <= 5) ? 8'h21 : 8'h59;
            checks++;
            if (ctl !== exp_ctl) begin
                $display("FAIL write_ctl edge %0d got %b want %b", e, ctl, exp_ctl); fails++;
            end
            if (e <= 10) begin
                checks++;
                if (ad_out !== exp_out) begin
                    $display("FAIL write_ad_out edge %0d got %h want %h", e, ad_out, exp_out); fails++;
                end
            end
            if (e == 2) begin wr_addr = 8'hFF; wr_data = 8'h00; end
            if (e == 11) wr_req = 1'b0;
        end
    endtask

    task automatic test_read;
        tick();
        rd_model_val = 8'h47; rd_addr = 8'h22; rd_req = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_ctl = {!(e <= 10), !(e >= 7 && e <= 9), !(e >= 2 && e <= 4),
                       !(e <= 5), (e <= 5), (e <= 11), 1'b0, (e == 11)};
            checks++;
            if (ctl !== exp_ctl) begin
                $display("FAIL read_ctl edge %0d got %b want %b", e, ctl, exp_ctl); fails++;
            end
            if (e <= 5) begin
                checks++;
                if (ad_out !== 8'h22) begin
                    $display("FAIL read_ad_out edge %0d got %h want 22", e, ad_out); fails++;
                end
            end
            if (e == 11 || e == 13) begin
                checks++;
                if (rd_data !== 8'h47) begin
                    $display("FAIL read_data edge %0d got %h want 47", e, rd_data); fails++;
                end
            end
            if (e == 11) rd_req = 1'b0;
        end
    endtask

    // Request withdrawn early: the cycle still completes and acks
    task automatic test_dropped_request;
        tick();
        rd_model_val = 8'h5C; rd_addr = 8'h33; rd_req = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 2) rd_req = 1'b0;
            checks++;
            if (rd_ack !== (e == 11)) begin
                $display("FAIL dropped_ack edge %0d got %b want %b", e, rd_ack, (e == 11)); fails++;
            end
            if (e == 11 || e == 14) begin
                checks++;
                if (rd_data !== 8'h5C) begin
                    $display("FAIL dropped_data edge %0d got %h want 5c", e, rd_data); fails++;
                end
            end
        end
        checks++;
        if (ctl !== 8'hF0) begin
            $display("FAIL dropped_idle got %b want %b", ctl, 8'hF0); fails++;
        end
    endtask

    task automatic test_contention;
        logic [3:0] obs, exp;
        tick();
        rd_model_val = 8'h3A;
        wr_addr = 8'h10; wr_data = 8'h01; rd_addr = 8'h11;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            obs = {CS, RD, wr_ack, rd_ack};
            exp = {!(e <= 10 || (e >= 13 && e <= 22)), !(e >= 19 && e <= 21),
                   (e == 11), (e == 23)};
            checks++;
            if (obs !== exp) begin
                $display("FAIL contention edge %0d got %b want %b", e, obs, exp); fails++;
            end
            if (e == 11) wr_req = 1'b0;
            if (e == 23) rd_req = 1'b0;
        end
        checks++;
        if (rd_data !== 8'h3A) begin
            $display("FAIL contention_data got %h want 3a", rd_data); fails++;
        end
    endtask

    task automatic test_held_request;
        logic [2:0] obs, exp;
        tick();
        wr_addr = 8'h40; wr_data = 8'h77; wr_req = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            obs = {CS, WR, wr_ack};
            exp = {!(e <= 10 || (e >= 13 && e <= 22)),
                   !((e >= 2 && e <= 4) || (e >= 7 && e <= 9) ||
                     (e >= 14 && e <= 16) || (e >= 19 && e <= 21)),
                   (e == 11 || e == 23)};
            checks++;
            if (obs !== exp) begin
                $display("FAIL held_req edge %0d got %b want %b", e, obs, exp); fails++;
            end
            if (e == 13) wr_req = 1'b0;
        end
    endtask

    // Reset asserted mid-write: outputs go idle on the next edge, no ack
    task automatic test_reset_mid_write;
        tick();
        wr_addr = 8'h55; wr_data = 8'hAA; wr_req = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 4) reset = 1'b1;
            if (e == 7) begin reset = 1'b0; wr_req = 1'b0; end
            if (e >= 5) begin
                checks++;
                if (ctl !== 8'hF0 || ad_out !== 8'h00) begin
                    $display("FAIL reset_mid edge %0d got ctl=%b ad_out=%h want %b/00",
                             e, ctl, ad_out, 8'hF0);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_default_timing;
        int rd_low, ack_edge, ack_cnt;
        rd_low = 0; ack_edge = -1; ack_cnt = 0;
        tick();
        d_rd_addr = 8'h30; d_rd_req = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (d_rd == 1'b0) rd_low++;
            checks++;
            if (d_rd !== !(e >= 17 && e <= 26)) begin
                $display("FAIL def_rd edge %0d got %b want %b", e, d_rd, !(e >= 17 && e <= 26));
                fails++;
            end
            if (d_rd_ack === 1'b1) begin
                ack_cnt++;
                ack_edge = e;
                d_rd_req = 1'b0;
            end
        end
        checks++;
        if (rd_low != 10) begin
            $display("FAIL def_rd_low_cycles got %0d want 10", rd_low); fails++;
        end
        checks++;
        if (ack_edge != 29 || ack_cnt != 1) begin
            $display("FAIL def_ack got edge %0d count %0d want edge 29 count 1", ack_edge, ack_cnt);
            fails++;
        end
        checks++;
        if (d_rd_data !== 8'hA5) begin
            $display("FAIL def_rd_data got %h want a5", d_rd_data); fails++;
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (viol != 0) begin
            $display("FAIL bus_invariants got %0d violations want 0", viol); fails++;
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
        rd_model_val = 8'h00;
        d_wr_req = 1'b0; d_rd_req = 1'b0;
        d_wr_addr = 8'h00; d_wr_data = 8'h00; d_rd_addr = 8'h00;

        test_reset();
        test_write();
        test_read();
        test_dropped_request();
        test_contention();
        test_held_request();
        test_reset_mid_write();
        test_default_timing();
        test_invariants();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
